// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch front end and the main control decoder.
package instr_fetch_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam int unsigned INSTR_STEP = 4;

    typedef enum logic [1:0] {
        StIdle,
        StWaitGnt,
        StWaitRsp,
        StDrop
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, instr} entries, with a single-cycle flush.
module fetch_queue #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign do_pop  = pop && (count_q != '0);
    // A full queue still takes a push when the head leaves in the same cycle.
    assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_valid = (count_q != '0);
    assign head_data  = mem_q[rd_ptr_q];
    assign count      = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: owns the PC, issues single-outstanding memory reads and
// queues the returned words for the decoder; a redirect flushes queued and in-flight fetches.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           INSTR_WIDTH  = 32,
    parameter int unsigned           OPCODE_WIDTH = 7,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0,
    parameter int unsigned           QUEUE_DEPTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    imem_req,
    output logic [ADDR_WIDTH-1:0]   imem_addr,
    input  logic                    imem_gnt,
    input  logic                    imem_rvalid,
    input  logic [INSTR_WIDTH-1:0]  imem_rdata,
    input  logic                    redirect_valid,
    input  logic [ADDR_WIDTH-1:0]   redirect_pc,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    output logic [INSTR_WIDTH-1:0]  instr,
    output logic [ADDR_WIDTH-1:0]   instr_pc,
    output logic [OPCODE_WIDTH-1:0] opcode
);

    localparam int unsigned ENTRY_W = ADDR_WIDTH + INSTR_WIDTH;
    localparam int unsigned CNT_W   = $clog2(QUEUE_DEPTH + 1);

    fetch_state_e          state_q;
    fetch_state_e          state_d;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic [ADDR_WIDTH-1:0] req_pc_q;
    logic [ADDR_WIDTH-1:0] req_pc_d;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic                  unused_redirect_lsb;

    logic                  q_push;
    logic                  q_pop;
    logic                  q_flush;
    logic                  q_valid;
    logic [ENTRY_W-1:0]    q_push_data;
    logic [ENTRY_W-1:0]    q_head;
    logic [CNT_W-1:0]      q_count;
    logic                  has_space;

    assign redirect_target     = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Only one request is ever in flight, so checking space at issue reserves the slot.
    assign has_space   = (q_count < CNT_W'(QUEUE_DEPTH));
    assign q_pop       = q_valid && instr_ready;
    assign q_push_data = {req_pc_q, imem_rdata};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        q_push   = 1'b0;
        q_flush  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!redirect_valid && has_space) begin
                    state_d = StWaitGnt;
                end
            end
            StWaitGnt: begin
                if (redirect_valid) begin
                    state_d = imem_gnt ? StDrop : StIdle;
                end else if (imem_gnt) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + ADDR_WIDTH'(INSTR_STEP);
                    state_d  = StWaitRsp;
                end
            end
            StWaitRsp: begin
                if (imem_rvalid) begin
                    q_push  = !redirect_valid;
                    state_d = StIdle;
                end else if (redirect_valid) begin
                    state_d = StDrop;
                end
            end
            StDrop: begin
                if (imem_rvalid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (redirect_valid) begin
            pc_d    = redirect_target;
            q_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    assign imem_req  = (state_q == StWaitGnt);
    assign imem_addr = pc_q;

    fetch_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_fetch_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (q_push),
        .push_data  (q_push_data),
        .pop        (q_pop),
        .flush      (q_flush),
        .head_valid (q_valid),
        .head_data  (q_head),
        .count      (q_count)
    );

    assign instr_valid = q_valid;
    assign instr_pc    = q_head[ENTRY_W-1:INSTR_WIDTH];
    assign instr       = q_head[INSTR_WIDTH-1:0];
    assign opcode      = q_head[OPCODE_WIDTH-1:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised bench for instr_fetch: a memory model plus a stream-level reference of the PCs
// the decoder should see (sequential, restarting at each redirect target).
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;

    always #5 clk = ~clk;

    instr_fetch #(
        .ADDR_WIDTH   (32),
        .INSTR_WIDTH  (32),
        .OPCODE_WIDTH (7),
        .RESET_PC     (RESET_PC),
        .QUEUE_DEPTH  (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .opcode         (opcode)
    );

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // Stimulus knobs
    int gnt_pct, lat_min, lat_max, ready_pct, redir_permil;
    bit gnt_block;
    bit redir_now;
    logic [31:0] redir_tgt;
    bit redir_gnt_en;
    logic [31:0] redir_gnt_addr, redir_gnt_tgt;
    bit ovr_en;
    logic [31:0] ovr_val;

    // Memory model and reference state
    bit rsp_pending;
    int rsp_wait;
    logic [31:0] rsp_addr;
    logic [31:0] issued[$];
    logic [31:0] acc_pcs[$];
    logic [31:0] exp_pc;
    int first_req_cyc, first_valid_cyc;
    logic [6:0] first_op;
    bit prev_hold;
    logic [31:0] prev_addr;

    logic        o_req, o_valid;
    logic [31:0] o_addr, o_instr, o_ipc;
    logic [6:0]  o_op;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0033;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int idx);
        if (idx < q.size()) return q[idx];
        return 'x;
    endfunction

    task automatic set_knobs(input int g, input int lmin, input int lmax, input int rdy,
                             input int rdr);
        gnt_pct = g; lat_min = lmin; lat_max = lmax; ready_pct = rdy; redir_permil = rdr;
    endtask

    task automatic cycle();
        logic        rv, g, rdy, rdv;
        logic [31:0] rd_data, tgt, w;
        @(negedge clk);
        cyc++;
        o_req = imem_req; o_addr = imem_addr; o_valid = instr_valid;
        o_instr = instr; o_ipc = instr_pc; o_op = opcode;
        if (o_req && first_req_cyc < 0) first_req_cyc = cyc;
        if (o_valid && first_valid_cyc < 0) begin
            first_valid_cyc = cyc;
            first_op = o_op;
        end

        if (prev_hold && o_req) check_eq("addr_stable", o_addr, prev_addr);
        if (rsp_pending) check_eq("one_outstanding", o_req, 0);

        rv = 1'b0;
        rd_data = $urandom;
        if (rsp_pending) begin
            if (rsp_wait == 0) begin
                rv = 1'b1;
                rd_data = ovr_en ? ovr_val : mem_word(rsp_addr);
                ovr_en = 1'b0;
                rsp_pending = 1'b0;
            end else begin
                rsp_wait--;
            end
        end

        g = o_req && !gnt_block && ($urandom_range(99) < gnt_pct);
        if (g) begin
            rsp_pending = 1'b1;
            rsp_addr = o_addr;
            rsp_wait = int'($urandom_range(lat_max, lat_min)) - 1;
            issued.push_back(o_addr);
        end

        rdy = ($urandom_range(99) < ready_pct);
        rdv = 1'b0;
        tgt = $urandom;
        if (redir_now) begin
            rdv = 1'b1; tgt = redir_tgt; redir_now = 1'b0;
        end else if (redir_gnt_en && g && o_addr == redir_gnt_addr) begin
            rdv = 1'b1; tgt = redir_gnt_tgt; redir_gnt_en = 1'b0;
        end else if ($urandom_range(999) < redir_permil) begin
            rdv = 1'b1; tgt = $urandom_range(4095);
        end

        imem_gnt = g; imem_rvalid = rv; imem_rdata = rd_data;
        instr_ready = rdy; redirect_valid = rdv; redirect_pc = tgt;

        // Decoder sees PCs in order, restarting at each redirect; a same-cycle pop is old stream.
        if (o_valid && rdy) begin
            w = mem_word(exp_pc);
            check_eq("instr_pc", o_ipc, exp_pc);
            check_eq("instr", o_instr, w);
            check_eq("opcode", o_op, w[6:0]);
            acc_pcs.push_back(exp_pc);
            exp_pc = exp_pc + 32'd4;
        end
        if (rdv) exp_pc = tgt & ~32'h3;
        prev_hold = o_req && !g;
        prev_addr = o_addr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; imem_rdata = '0;
        rsp_pending = 1'b0; ovr_en = 1'b0; redir_now = 1'b0; redir_gnt_en = 1'b0;
        gnt_block = 1'b0; prev_hold = 1'b0;
        issued.delete(); acc_pcs.delete();
        exp_pc = RESET_PC; first_req_cyc = -1; first_valid_cyc = -1; first_op = '0; cyc = 0;
        repeat (2) @(negedge clk);
        check_eq("rst_req", imem_req, 0);
        check_eq("rst_valid", instr_valid, 0);
        check_eq("rst_instr", instr, 0);
        check_eq("rst_instr_pc", instr_pc, 0);
        check_eq("rst_opcode", opcode, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n_req;

        // Zero-wait memory: ordered issue and two-cycle latency from first request.
        set_knobs(100, 1, 1, 100, 0);
        do_reset();
        for (int i = 0; i < 40 && acc_pcs.size() < 3; i++) cycle();
        check_eq("t1_issue0", q_at(issued, 0), 32'h0);
        check_eq("t1_issue1", q_at(issued, 1), 32'h4);
        check_eq("t1_issue2", q_at(issued, 2), 32'h8);
        check_eq("t1_latency", first_valid_cyc - first_req_cyc, 2);
        check_eq("t1_acc2", q_at(acc_pcs, 2), 32'h8);
        check_eq("t1_opcode", first_op, OP_RTYPE);

        // Decoder stalled: queue fills to two entries and issue stops.
        set_knobs(100, 1, 1, 0, 0);
        do_reset();
        n_req = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (i >= 10 && o_req) n_req++;
        end
        check_eq("t2_grants", issued.size(), 2);
        check_eq("t2_req_idle", n_req, 0);
        check_eq("t2_head_valid", o_valid, 1);
        ready_pct = 100;
        for (int i = 0; i < 40 && acc_pcs.size() < 3; i++) cycle();
        check_eq("t2_drain0", q_at(acc_pcs, 0), 32'h0);
        check_eq("t2_drain1", q_at(acc_pcs, 1), 32'h4);
        check_eq("t2_resume", q_at(issued, 2), 32'h8);

        // Grant withheld: request and address hold steady.
        set_knobs(100, 1, 1, 100, 0);
        do_reset();
        gnt_block = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_eq("t3_req_held", o_req, 1);
            check_eq("t3_addr_held", o_addr, 32'h0);
        end
        gnt_block = 1'b0;
        for (int i = 0; i < 20 && issued.size() < 2; i++) cycle();
        check_eq("t3_issue0", q_at(issued, 0), 32'h0);
        check_eq("t3_issue1", q_at(issued, 1), 32'h4);

        // Redirect while waiting for a slow response with one entry queued.
        set_knobs(100, 4, 4, 0, 0);
        do_reset();
        for (int i = 0; i < 40 && issued.size() < 2; i++) cycle();
        check_eq("t4_setup", issued.size(), 2);
        redir_now = 1'b1; redir_tgt = 32'h103;
        ovr_en = 1'b1; ovr_val = 32'hDEAD_BEEF;
        cycle();
        cycle();
        check_eq("t4_flushed", o_valid, 0);
        set_knobs(100, 1, 1, 100, 0);
        for (int i = 0; i < 60 && acc_pcs.size() < 1; i++) cycle();
        check_eq("t4_first_pc", q_at(acc_pcs, 0), 32'h100);
        check_eq("t4_next_issue", q_at(issued, 2), 32'h100);

        // Redirect in the grant cycle of the fetch for 0x8.
        set_knobs(100, 2, 2, 100, 0);
        do_reset();
        redir_gnt_en = 1'b1; redir_gnt_addr = 32'h8; redir_gnt_tgt = 32'h200;
        for (int i = 0; i < 60 && acc_pcs.size() < 3; i++) cycle();
        check_eq("t5_issue2", q_at(issued, 2), 32'h8);
        check_eq("t5_issue3", q_at(issued, 3), 32'h200);
        check_eq("t5_acc1", q_at(acc_pcs, 1), 32'h4);
        check_eq("t5_acc2", q_at(acc_pcs, 2), 32'h200);

        // Asynchronous reset while waiting for a grant with one entry queued.
        set_knobs(100, 1, 1, 0, 0);
        do_reset();
        for (int i = 0; i < 10 && issued.size() < 1; i++) cycle();
        gnt_block = 1'b1;
        for (int i = 0; i < 20 && !(o_valid && o_req); i++) cycle();
        check_eq("t6_setup", o_valid && o_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_req_drop", imem_req, 0);
        check_eq("t6_valid_drop", instr_valid, 0);
        set_knobs(100, 1, 1, 100, 0);
        do_reset();
        for (int i = 0; i < 10 && issued.size() < 1; i++) cycle();
        check_eq("t6_restart", q_at(issued, 0), RESET_PC);

        // Random traffic against the stream model.
        set_knobs(60, 1, 3, 70, 30);
        do_reset();
        for (int i = 0; i < 3000; i++) cycle();
        check_eq("rand_progress", acc_pcs.size() >= 100, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch front end: owns the PC, requests 32-bit words from instruction memory, and buffers them in a small queue.
- Presents instructions to the main control decoder with a valid/ready handshake; the opcode field is broken out separately.
- Accepts a branch/jump redirect that flushes buffered and in-flight fetches.
- Sits between the instruction memory port and the decode/control stage.

Parameters:
- ADDR_WIDTH, 32, PC and memory address width.
- INSTR_WIDTH, 32, instruction word width.
- OPCODE_WIDTH, 7, width of the opcode field instr[6:0].
- RESET_PC, 0, PC loaded at reset; must be 4-byte aligned.
- QUEUE_DEPTH, 2, entries in the fetch queue; 2 minimum.

Ports:
- clk  input  1  single clock; all state on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- imem_req  output  1  fetch request.
- imem_addr  output  ADDR_WIDTH  fetch address; stable while imem_req=1 and imem_gnt=0.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  read data valid; exactly one per granted request, at least 1 cycle after gnt.
- imem_rdata  input  INSTR_WIDTH  instruction word.
- redirect_valid  input  1  PC redirect (taken branch/jump).
- redirect_pc  input  ADDR_WIDTH  new PC; bits[1:0] ignored (forced to 0).
- instr_valid  output  1  queue head valid.
- instr_ready  input  1  decoder accepts head.
- instr  output  INSTR_WIDTH  head instruction.
- instr_pc  output  ADDR_WIDTH  PC of head instruction.
- opcode  output  OPCODE_WIDTH  instr[6:0] of head.

Behaviour:
- Reset values: pc = RESET_PC; state IDLE; queue empty; imem_req = 0; instr_valid = 0; instr, instr_pc and opcode = 0.
- Reset is honoured mid-transaction. Any response arriving after reset release that belongs to a pre-reset request is the memory's responsibility; the memory is reset with the same rst_n.
- At most one outstanding request.
- FSM:
  - IDLE: if (queue_count + 0) < QUEUE_DEPTH and no redirect, assert imem_req with imem_addr = pc and go to WAIT_GNT. The request is driven from registered state, so req rises the cycle after entering IDLE with space.
  - WAIT_GNT: imem_req = 1, imem_addr = pc held.
    - On gnt: latch req_pc = pc, pc <= pc + 4 (wraps modulo 2^ADDR_WIDTH), go to WAIT_RSP.
  - WAIT_RSP: imem_req = 0.
    - On rvalid: push {req_pc, imem_rdata} into the queue, go to IDLE.
    - Space is reserved at issue, so the push never overflows.
  - DROP: imem_req = 0.
    - On rvalid: discard data, go to IDLE.
- Redirect (priority over all other events in its cycle):
  - pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}; queue flushed (count = 0, instr_valid = 0 next cycle).
  - A pop coinciding with a redirect still completes from the decoder's view; no extra entry survives.
  - In IDLE, or in WAIT_GNT without gnt: request withdrawn, go to IDLE. The memory protocol permits withdrawal before gnt.
  - In WAIT_GNT with gnt the same cycle: go to DROP.
  - In WAIT_RSP without rvalid: go to DROP.
  - In WAIT_RSP with rvalid the same cycle: response discarded, go to IDLE.
  - In DROP: stay in DROP until rvalid; a redirect_pc arriving here still updates pc.
- Queue:
  - Registered outputs; head visible the cycle after push.
  - Pop when instr_valid && instr_ready.
  - Simultaneous push and pop is allowed at any occupancy, count unchanged.
  - Pop on empty: ignored.
- Latency: with gnt in the issue cycle and rvalid one cycle later, instr_valid rises 2 cycles after imem_req first asserts.
- Throughput: 1 instruction per 3 cycles (single outstanding request, issue from IDLE).
- Flow control: instr_ready held low fills the queue; issue then stalls, with imem_req = 0 while full.

Decomposition:
- Shared package: opcode constants OP_RTYPE=7'b0110011, OP_LOAD=7'b0000011, OP_STORE=7'b0100011, OP_BRANCH=7'b1100011 (shared with the control decoder); fetch FSM state encoding IDLE/WAIT_GNT/WAIT_RSP/DROP; instruction step constant 4.
- One sub-module: fetch_queue, a parameterised synchronous FIFO with flush (data = {pc, instr}), count output, push/pop/flush inputs.

Test Plan:
- Reset, zero-wait memory (gnt same cycle, rvalid +1), instr_ready=1 → addresses 0x0, 0x4, 0x8 issued in order; instr_valid first high 2 cycles after first req; instr_pc matches; opcode for word 0x00000033 = 7'b0110011.
- instr_ready=0 for 20 cycles → exactly 2 entries queued, imem_req stays 0; release ready → entries drain in order, fetch resumes at 0x8.
- Hold imem_gnt=0 for 5 cycles → imem_req=1 and imem_addr=0x0 stable throughout; on gnt, pc advances to 0x4.
- Redirect to 0x103 while in WAIT_RSP, rvalid 3 cycles later with 0xDEADBEEF → data discarded, queue empty, next request to 0x100, instr_pc=0x100.
- Redirect to 0x200 in the same cycle as gnt for 0x8 → FSM enters DROP; response for 0x8 never appears at instr; next fetch 0x200.
- Assert rst_n=0 asynchronously mid-WAIT_GNT with 1 queued entry → imem_req and instr_valid drop immediately; after release, first fetch is RESET_PC.
